fetch_queue: RTL and testbench

- Decoupling buffer directly downstream of the PC/IF adder stage, upstream of decode.
- Captures the PC, PC+2 and fetched instruction each cycle IF produces one.
- Holds up to DEPTH entries in a circular FIFO and presents them in order to ID through a valid/ready handshake.
- Absorbs decode stalls; discards all contents on a branch/jump flush.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_storage.sv | 39 +++
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch path.
//   ADDR_W        PC width
//   INSTR_W       instruction word width
//   fetch_entry_t one fetch record {pc, pc_plus2, instr}
//   PC_STEP       PC increment applied by the IF adder
package fetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus2;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [ADDR_W-1:0] PC_STEP = 16'h0002;

endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: DEPTH-entry register array of fetch_entry_t.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset, clears every entry to 0
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index (asynchronous read)
//   rdata  read data
module fetch_queue_storage
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  fetch_entry_t       wdata,
    input  logic [PTR_W-1:0]   raddr,
    output fetch_entry_t       rdata
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO between IF and ID holding {pc, pc_plus2, instr}.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// entry is presented to ID in the same cycle and is not stored if ID takes it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      drop all queued entries (branch/jump redirect)
//   in_valid/in_ready          IF-side handshake; in_ready = (count != DEPTH)
//   in_pc/in_pc_plus2/in_instr entry from IF
//   out_valid/out_ready        ID-side handshake
//   out_pc/out_pc_plus2/out_instr head entry, 0 when out_valid = 0
//   count                      current occupancy
module fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [ADDR_W-1:0]  in_pc_plus2,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus2,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   count
);

    import fetch_pkg::*;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic         not_empty;
    logic         push;
    logic         pop;
    logic         bypass;
    fetch_entry_t in_entry;
    fetch_entry_t head_entry;
    fetch_entry_t out_entry;

    assign in_entry.pc       = in_pc;
    assign in_entry.pc_plus2 = in_pc_plus2;
    assign in_entry.instr    = in_instr;

    assign not_empty = (count_q != '0);
    // Depends only on state, never on out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset is included so outputs stay quiet while reset is held.
    assign bypass = !not_empty && in_valid && !flush && !reset;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by ID that cycle is never written.
    assign push = in_valid && in_ready && !(bypass && out_ready);
    assign pop  = not_empty && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .reset (reset),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (in_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    always_comb begin
        out_entry = '0;
        if (bypass) begin
            out_entry = in_entry;
        end else if (not_empty) begin
            out_entry = head_entry;
        end
    end

    assign out_valid    = not_empty || bypass;
    assign out_pc       = out_entry.pc;
    assign out_pc_plus2 = out_entry.pc_plus2;
    assign out_instr    = out_entry.instr;
    assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_pc_plus2;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus2;
    logic [15:0] out_instr;
    logic [2:0]  count;

    int checks;
    int errors;

    fetch_queue #(
        .DEPTH   (4),
        .ADDR_W  (16),
        .INSTR_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_pc_plus2  (in_pc_plus2),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus2 (out_pc_plus2),
        .out_instr    (out_instr),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc);
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus2 = pc + 16'h0002;
        in_instr    = 16'hA000 | pc;
    endtask

    task automatic check_head(input string tag, input logic [15:0] pc);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"}, {16'd0, out_pc}, {16'd0, pc});
        check({tag, "_pc2"}, {16'd0, out_pc_plus2}, {16'd0, pc + 16'h0002});
        check({tag, "_instr"}, {16'd0, out_instr}, {16'd0, 16'hA000 | pc});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'h0100);

        // 1. Reset with in_valid high.
        tick();
        tick();
        #1;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_pc", {16'd0, out_pc}, 32'd0);
        check("rst_out_pc2", {16'd0, out_pc_plus2}, 32'd0);
        check("rst_out_instr", {16'd0, out_instr}, 32'd0);

        // 2. Fill with 0,2,4,6; release reset with the first push presented.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(2 * i));
            tick();
            check($sformatf("fill_count%0d", i), {29'd0, count}, 32'(i + 1));
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 16'h0008);
        tick();
        check("full_reject_count", {29'd0, count}, 32'd4);
        check_head("full_head", 16'h0000);

        // 3. Drain in order.
        drive(1'b0, 16'h0000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_head($sformatf("drain%0d", i), 16'(2 * i));
            tick();
        end
        check("drained_valid", {31'd0, out_valid}, 32'd0);
        check("drained_count", {29'd0, count}, 32'd0);
        check("drained_pc", {16'd0, out_pc}, 32'd0);

        // 4. Steady stream at count=2 across the pointer wrap.
        out_ready = 1'b0;
        drive(1'b1, 16'h0020);
        tick();
        drive(1'b1, 16'h0022);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0024 + 2 * i));
            #1;
            check_head($sformatf("stream%0d", i), 16'(16'h0020 + 2 * i));
            tick();
            check($sformatf("stream_count%0d", i), {29'd0, count}, 32'd2);
        end

        // 5. Three queued, then flush with push and pop requested.
        out_ready = 1'b0;
        drive(1'b1, 16'h002C);
        tick();
        check("pre_flush_count", {29'd0, count}, 32'd3);
        check_head("pre_flush_head", 16'h0028);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h0030);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000);
        #1;
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 16'h0040);
        tick();
        drive(1'b0, 16'h0000);
        #1;
        check("post_flush_count", {29'd0, count}, 32'd1);
        check_head("post_flush_head", 16'h0040);

        // Empty it again.
        out_ready = 1'b1;
        tick();
        check("empty_again", {29'd0, count}, 32'd0);

        // 6. Empty queue with in_valid and out_ready both high.
        drive(1'b1, 16'h0010);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_head("bypass_same", 16'h0010);
`else
        check("nobypass_same_valid", {31'd0, out_valid}, 32'd0);
`endif
        tick();
        drive(1'b0, 16'h0000);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_count", {29'd0, count}, 32'd0);
        check("bypass_after_valid", {31'd0, out_valid}, 32'd0);
`else
        check("nobypass_count", {29'd0, count}, 32'd1);
        check_head("nobypass_next", 16'h0010);
        tick();
`endif

        // Reset mid-operation wins over flush.
        out_ready = 1'b0;
        drive(1'b1, 16'h0050);
        tick();
        drive(1'b1, 16'h0052);
        tick();
        check("mid_count", {29'd0, count}, 32'd2);
        drive(1'b0, 16'h0000);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
